// File: rtl/m_shr_arbiter_pkg.sv
// Shared Kestrel-2 bus definitions: arbiter state
// encodings and the default bus watchdog limit.
package m_shr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/m_bus_watchdog.sv
// Bus wait counter: counts un-acked strobe cycles and
// flags the cycle on which the limit is reached.
module m_bus_watchdog
    import m_shr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (ack || !stb || clr) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expire = stb && !ack && (r_cnt == LIMIT);

endmodule

// File: rtl/m_shr_arbiter.sv
// Two-master Wishbone arbiter onto the shared Kestrel-2 bus
// (m0 = video fetch, m1 = J1 CPU) with a bus watchdog.
module m_shr_arbiter
    import m_shr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        sys_clk_i,
    input  logic        sys_res_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [15:1] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [15:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [15:1] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [15:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [15:1] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [15:0] s_dat_i,
    output logic [1:0]  gnt_o
);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last;
    logic       w_g0;
    logic       w_g1;
    logic       w_expire;
    logic       w_clr;

    assign w_g0 = (r_state == ST_GNT0);
    assign w_g1 = (r_state == ST_GNT1);

    // Watchdog restarts whenever the grant is about to move.
    assign w_clr = (w_next != r_state);

    m_bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (sys_clk_i),
        .rst_n (sys_res_i),
        .stb   (s_stb_o),
        .ack   (s_ack_i),
        .clr   (w_clr),
        .expire(w_expire)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = r_last ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    w_next = ST_GNT0;
                end else if (m1_cyc_i) begin
                    w_next = ST_GNT1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (w_expire) begin
                    w_next = ST_IDLE;
                end else if (m0_cyc_i) begin
                    w_next = ST_GNT0;
                end else if (m1_cyc_i) begin
                    w_next = ST_GNT1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (w_expire) begin
                    w_next = ST_IDLE;
                end else if (m1_cyc_i) begin
                    w_next = ST_GNT1;
                end else if (m0_cyc_i) begin
                    w_next = ST_GNT0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_res_i) begin
        if (!sys_res_i) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_g0 && (w_next != ST_GNT0)) begin
                r_last <= 1'b0;
            end else if (w_g1 && (w_next != ST_GNT1)) begin
                r_last <= 1'b1;
            end
        end
    end

    // Bus side depends only on state and master inputs, never on s_ack_i.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_g0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (w_g1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = w_g0 && m0_stb_i && s_ack_i;
    assign m1_ack_o = w_g1 && m1_stb_i && s_ack_i;
    assign m0_err_o = w_g0 && w_expire;
    assign m1_err_o = w_g1 && w_expire;
    assign m0_dat_o = w_g0 ? s_dat_i : 16'h0000;
    assign m1_dat_o = w_g1 ? s_dat_i : 16'h0000;
    assign gnt_o    = {w_g1, w_g0};

endmodule

// File: tb/tb_m_shr_arbiter.sv
// Self-checking bench for m_shr_arbiter: directed table,
// corner sequences and random traffic against a model.
module tb_m_shr_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c0 = 0, s0 = 0, w0 = 0;
    logic [15:1] a0 = '0;
    logic [15:0] d0 = '0;
    logic        c1 = 0, s1 = 0, w1 = 0;
    logic [15:1] a1 = '0;
    logic [15:0] d1 = '0;
    logic        sack = 0;
    logic [15:0] sdat = '0;

    logic        ack0, err0, ack1, err1;
    logic [15:0] dat0, dat1;
    logic        scyc, sstb, swe;
    logic [15:1] sadr;
    logic [15:0] sdo;
    logic [1:0]  gnt;

    int total = 0;
    int bad = 0;

    // Model: granted master index (-1 = none), last, wait count
    int gm = -1;
    int lst = 1;
    int wcnt = 0;

    always #5 clk = ~clk;

    m_shr_arbiter #(.TIMEOUT(TO)) dut (
        .sys_clk_i(clk), .sys_res_i(rst_n),
        .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(w0),
        .m0_adr_i(a0), .m0_dat_i(d0),
        .m0_ack_o(ack0), .m0_err_o(err0), .m0_dat_o(dat0),
        .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(w1),
        .m1_adr_i(a1), .m1_dat_i(d1),
        .m1_ack_o(ack1), .m1_err_o(err1), .m1_dat_o(dat1),
        .s_cyc_o(scyc), .s_stb_o(sstb), .s_we_o(swe),
        .s_adr_o(sadr), .s_dat_o(sdo),
        .s_ack_i(sack), .s_dat_i(sdat),
        .gnt_o(gnt)
    );

    function automatic logic mstb(int n);
        return (n == 0) ? s0 : s1;
    endfunction

    function automatic logic mcyc(int n);
        return (n == 0) ? c0 : c1;
    endfunction

    function automatic logic model_err();
        return (gm >= 0) && mstb(gm) && !sack && (wcnt == TO - 1);
    endfunction

    function automatic logic [71:0] model_out();
        logic cy, st, we, ea, ee;
        logic [14:0] ad;
        logic [15:0] dt;
        logic xa0, xe0, xa1, xe1;
        logic [15:0] xd0, xd1;
        logic [1:0] g;
        {cy, st, we, ad, dt} = '0;
        {xa0, xe0, xa1, xe1, xd0, xd1, g} = '0;
        if (gm == 0) {cy, st, we, ad, dt} = {c0, s0, w0, a0, d0};
        if (gm == 1) {cy, st, we, ad, dt} = {c1, s1, w1, a1, d1};
        ea = st && sack;
        ee = model_err();
        if (gm == 0) begin
            xa0 = ea; xe0 = ee; xd0 = sdat; g = 2'b01;
        end
        if (gm == 1) begin
            xa1 = ea; xe1 = ee; xd1 = sdat; g = 2'b10;
        end
        return {g, cy, st, we, ad, dt, xa0, xe0, xd0, xa1, xe1, xd1};
    endfunction

    function automatic logic [71:0] dut_out();
        return {gnt, scyc, sstb, swe, sadr, sdo,
                ack0, err0, dat0, ack1, err1, dat1};
    endfunction

    task automatic model_edge();
        int ng;
        if (gm < 0) begin
            if (c0 && c1) ng = (lst == 1) ? 0 : 1;
            else if (c0) ng = 0;
            else if (c1) ng = 1;
            else ng = -1;
            wcnt = 0;
        end else begin
            if (model_err()) ng = -1;
            else if (mcyc(gm)) ng = gm;
            else if (mcyc(1 - gm)) ng = 1 - gm;
            else ng = -1;
            if (ng != gm || !mstb(gm) || sack) wcnt = 0;
            else wcnt = wcnt + 1;
            if (ng != gm) lst = gm;
        end
        gm = ng;
    endtask

    task automatic model_reset();
        gm = -1;
        lst = 1;
        wcnt = 0;
    endtask

    task automatic chk(string nm, logic [71:0] got, logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic clr_in();
        {c0, s0, w0, a0, d0} = '0;
        {c1, s1, w1, a1, d1} = '0;
        sack = 0;
        sdat = '0;
    endtask

    task automatic mid();
        #4;
        chk("model", dut_out(), model_out());
    endtask

    task automatic fin();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr_in();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    typedef struct {
        logic        c0, s0, c1, s1, sack;
        logic [15:0] sdat;
        logic [1:0]  gnt;
        logic [15:1] sadr;
        logic        ack0, ack1;
        logic [15:0] dat0;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // c0 s0 c1 s1 ack sdat | gnt sadr ack0 ack1 dat0
        tbl[0]  = '{0, 0, 1, 1, 0, 16'h0000, 2'b00, 15'h0, 0, 0, 16'h0};
        tbl[1]  = '{0, 0, 1, 1, 1, 16'h1111, 2'b10, 15'h3, 0, 1, 16'h0};
        tbl[2]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b10, 15'h3, 0, 0, 16'h0};
        tbl[3]  = '{1, 1, 1, 1, 0, 16'h0000, 2'b00, 15'h0, 0, 0, 16'h0};
        tbl[4]  = '{1, 1, 1, 1, 1, 16'h5a5a, 2'b01, 15'h5, 1, 0, 16'h5a5a};
        tbl[5]  = '{0, 0, 1, 1, 0, 16'h0000, 2'b01, 15'h5, 0, 0, 16'h0};
        tbl[6]  = '{0, 0, 1, 1, 0, 16'h0000, 2'b10, 15'h3, 0, 0, 16'h0};
        tbl[7]  = '{1, 1, 1, 1, 1, 16'habcd, 2'b10, 15'h3, 0, 1, 16'h0};
        tbl[8]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b10, 15'h3, 0, 0, 16'h0};
        tbl[9]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b00, 15'h0, 0, 0, 16'h0};
        tbl[10] = '{1, 1, 1, 1, 0, 16'h0000, 2'b00, 15'h0, 0, 0, 16'h0};
        tbl[11] = '{1, 1, 1, 1, 0, 16'h0000, 2'b01, 15'h5, 0, 0, 16'h0};

        rst_n = 0;
        #1;
        chk("reset_outputs", dut_out(), 72'h0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            c0 = tbl[i].c0; s0 = tbl[i].s0;
            c1 = tbl[i].c1; s1 = tbl[i].s1;
            a0 = 15'h5; a1 = 15'h3;
            sack = tbl[i].sack; sdat = tbl[i].sdat;
            mid();
            chk($sformatf("tbl%0d_gnt", i), 72'(gnt), 72'(tbl[i].gnt));
            chk($sformatf("tbl%0d_adr", i), 72'(sadr), 72'(tbl[i].sadr));
            chk($sformatf("tbl%0d_ack0", i), 72'(ack0), 72'(tbl[i].ack0));
            chk($sformatf("tbl%0d_ack1", i), 72'(ack1), 72'(tbl[i].ack1));
            chk($sformatf("tbl%0d_dat0", i), 72'(dat0), 72'(tbl[i].dat0));
            fin();
        end

        // timeout on the 15th un-acked strobe cycle
        do_reset();
        c0 = 1; s0 = 1; a0 = 15'h7;
        mid(); fin();
        for (int k = 1; k <= TO; k++) begin
            mid();
            chk($sformatf("to_err_k%0d", k), 72'(err0), 72'(k == TO));
            fin();
        end
        mid();
        chk("to_gnt_after", 72'(gnt), 72'(2'b00));
        chk("to_stb_after", 72'(sstb), 72'(1'b0));
        fin();

        // ack on the 15th wait cycle beats the timeout
        do_reset();
        c0 = 1; s0 = 1;
        mid(); fin();
        for (int k = 1; k <= TO; k++) begin
            sack = (k == TO);
            mid();
            if (k == TO) begin
                chk("ackwin_ack", 72'(ack0), 72'(1'b1));
                chk("ackwin_err", 72'(err0), 72'(1'b0));
            end
            fin();
        end
        sack = 0;
        mid();
        chk("ackwin_gnt", 72'(gnt), 72'(2'b01));
        fin();

        // timeout while m1 waits: m1 wins next arbitration
        do_reset();
        c0 = 1; s0 = 1; c1 = 1; s1 = 1;
        for (int k = 0; k < TO + 2; k++) begin
            mid(); fin();
        end
        mid();
        chk("to_other_wins", 72'(gnt), 72'(2'b10));
        fin();

        // reset asserted mid-write
        do_reset();
        c1 = 1; s1 = 1; w1 = 1; a1 = 15'h44; d1 = 16'h9234;
        mid(); fin();
        mid();
        rst_n = 0;
        #1;
        chk("rstmid_cyc", 72'(scyc), 72'(1'b0));
        chk("rstmid_we", 72'(swe), 72'(1'b0));
        chk("rstmid_dat", 72'(sdo), 72'(16'h0));
        chk("rstmid_gnt", 72'(gnt), 72'(2'b00));
        do_reset();

        // random traffic
        begin
            logic aen;
            aen = 1;
            for (int n = 0; n < 3000; n++) begin
                if ((n % 97) == 0) aen = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 7) == 0) c0 = ~c0;
                if ($urandom_range(0, 7) == 0) c1 = ~c1;
                s0 = c0 && ($urandom_range(0, 3) != 0);
                s1 = c1 && ($urandom_range(0, 3) != 0);
                w0 = 1'($urandom); w1 = 1'($urandom);
                a0 = 15'($urandom); a1 = 15'($urandom);
                d0 = 16'($urandom); d1 = 16'($urandom);
                sdat = 16'($urandom);
                sack = aen && ($urandom_range(0, 2) == 0);
                mid();
                fin();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
